// File: rtl/sid_pkg.sv
// Shared widths, divider state encoding and output scaling for the SID
// audio decimator.
package sid_pkg;

  localparam int SID_AUDIO_W = 18;
  localparam int DEC_ACC_W   = 24;
  localparam int DEC_CNT_W   = 6;
  localparam int DIV_STEPS   = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Arithmetic floor by 4 of the 18-bit average down to the 16-bit output.
  function automatic logic signed [15:0] scale_q(input logic signed [SID_AUDIO_W-1:0] q);
    return 16'(q >>> 2);
  endfunction

endpackage

// File: rtl/sid_div.sv
// Sequential restoring divider: signed 24-bit dividend by unsigned 6-bit
// divisor, one quotient bit per clk on the magnitude, sign restored at the end.
module sid_div
  import sid_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic signed [DEC_ACC_W-1:0]   dividend,
  input  logic        [DEC_CNT_W-1:0]   divisor,
  output logic                          done,
  output logic signed [SID_AUDIO_W-1:0] quotient
);

  div_state_e                   state_r;
  logic [DEC_ACC_W-1:0]         work_r;
  logic [DEC_CNT_W-1:0]         rem_r;
  logic [DEC_CNT_W-1:0]         dsr_r;
  logic                         neg_r;
  logic [4:0]                   step_r;

  logic [DEC_ACC_W-1:0]         mag_s;
  logic [DEC_CNT_W:0]           shifted_s;
  logic                         ge_s;
  logic [DEC_CNT_W-1:0]         rem_next_s;
  logic [DEC_ACC_W-1:0]         work_next_s;
  logic signed [SID_AUDIO_W-1:0] q_final_s;

  // One restoring step; quotient bits shift into the low end of work_r.
  always_comb begin
    if (dividend[DEC_ACC_W-1]) begin
      mag_s = ~dividend + 24'd1;
    end else begin
      mag_s = dividend;
    end
    shifted_s = {rem_r, work_r[DEC_ACC_W-1]};
    ge_s      = (shifted_s >= {1'b0, dsr_r});
    if (ge_s) begin
      rem_next_s = 6'(shifted_s - {1'b0, dsr_r});
    end else begin
      rem_next_s = shifted_s[DEC_CNT_W-1:0];
    end
    work_next_s = {work_r[DEC_ACC_W-2:0], ge_s};
    if (neg_r) begin
      q_final_s = 18'(~work_next_s + 24'd1);
    end else begin
      q_final_s = 18'(work_next_s);
    end
  end

  // Divider sequencer: IDLE -> RUN (24 clks) -> DONE -> IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= IDLE;
      work_r   <= 24'd0;
      rem_r    <= 6'd0;
      dsr_r    <= 6'd0;
      neg_r    <= 1'b0;
      step_r   <= 5'd0;
      done     <= 1'b0;
      quotient <= 18'sd0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            work_r  <= mag_s;
            neg_r   <= dividend[DEC_ACC_W-1];
            dsr_r   <= divisor;
            rem_r   <= 6'd0;
            step_r  <= 5'd0;
            state_r <= RUN;
          end
        end
        RUN: begin
          work_r <= work_next_s;
          rem_r  <= rem_next_s;
          step_r <= step_r + 5'd1;
          if (step_r == 5'(DIV_STEPS - 1)) begin
            quotient <= q_final_s;
            done     <= 1'b1;
            state_r  <= DONE;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/sid_decimator.sv
// Decimates 1 MHz SID stereo audio to OUT_RATE by window averaging, with a
// valid/ready output register and a sticky overrun flag.
module sid_decimator
  import sid_pkg::*;
#(
  parameter int IN_RATE  = 1000000,
  parameter int OUT_RATE = 48000
)
(
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          ce_1m,
  input  logic signed [SID_AUDIO_W-1:0] audio_l,
  input  logic signed [SID_AUDIO_W-1:0] audio_r,
  output logic signed [15:0]            out_l,
  output logic signed [15:0]            out_r,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          overrun
);

  logic [19:0]                   phase_r;
  logic signed [DEC_ACC_W-1:0]   acc_left_r;
  logic signed [DEC_ACC_W-1:0]   acc_right_r;
  logic [DEC_CNT_W-1:0]          cnt_r;
  logic                          start_r;
  logic signed [DEC_ACC_W-1:0]   sum_left_r;
  logic signed [DEC_ACC_W-1:0]   sum_right_r;
  logic [DEC_CNT_W-1:0]          n_r;

  logic [20:0]                   phase_inc_s;
  logic                          close_s;
  logic [19:0]                   phase_next_s;
  logic signed [DEC_ACC_W-1:0]   sum_left_s;
  logic signed [DEC_ACC_W-1:0]   sum_right_s;
  logic                          done_left_s;
  logic                          done_right_s;
  logic signed [SID_AUDIO_W-1:0] q_left_s;
  logic signed [SID_AUDIO_W-1:0] q_right_s;

  // Phase step, window-close decision and running sums including this sample.
  always_comb begin
    phase_inc_s = {1'b0, phase_r} + 21'(OUT_RATE);
    close_s     = (phase_inc_s >= 21'(IN_RATE));
    if (close_s) begin
      phase_next_s = 20'(phase_inc_s - 21'(IN_RATE));
    end else begin
      phase_next_s = phase_inc_s[19:0];
    end
    sum_left_s  = acc_left_r  + {{(DEC_ACC_W-SID_AUDIO_W){audio_l[SID_AUDIO_W-1]}}, audio_l};
    sum_right_s = acc_right_r + {{(DEC_ACC_W-SID_AUDIO_W){audio_r[SID_AUDIO_W-1]}}, audio_r};
  end

  // Accumulate on every ce_1m; on window close hand the totals to the dividers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_r     <= 20'd0;
      acc_left_r  <= 24'sd0;
      acc_right_r <= 24'sd0;
      cnt_r       <= 6'd0;
      start_r     <= 1'b0;
      sum_left_r  <= 24'sd0;
      sum_right_r <= 24'sd0;
      n_r         <= 6'd0;
    end else begin
      start_r <= 1'b0;
      if (ce_1m) begin
        phase_r <= phase_next_s;
        if (close_s) begin
          sum_left_r  <= sum_left_s;
          sum_right_r <= sum_right_s;
          n_r         <= cnt_r + 6'd1;
          start_r     <= 1'b1;
          acc_left_r  <= 24'sd0;
          acc_right_r <= 24'sd0;
          cnt_r       <= 6'd0;
        end else begin
          acc_left_r  <= sum_left_s;
          acc_right_r <= sum_right_s;
          cnt_r       <= cnt_r + 6'd1;
        end
      end
    end
  end

  sid_div u_div_left (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start_r),
    .dividend (sum_left_r),
    .divisor  (n_r),
    .done     (done_left_s),
    .quotient (q_left_s)
  );

  sid_div u_div_right (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start_r),
    .dividend (sum_right_r),
    .divisor  (n_r),
    .done     (done_right_s),
    .quotient (q_right_s)
  );

  // Output register: a held, untaken sample wins over a new one (overrun).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_l     <= 16'sd0;
      out_r     <= 16'sd0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (done_left_s && done_right_s) begin
      if (!out_valid || out_ready) begin
        out_l     <= scale_q(q_left_s);
        out_r     <= scale_q(q_right_s);
        out_valid <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/sid_decimator.md
SID_DECIMATOR -- requirements
Module: sid_decimator

Interface
REQ-001 SHALL have parameter IN_RATE, default 1000000: input sample rate in Hz, i.e. the rate of ce_1m.
REQ-002 SHALL have parameter OUT_RATE, default 48000: output sample rate in Hz; legal range 16000..IN_RATE/2.
REQ-003 SHALL have port clk  in  1  system clock; its frequency is at least 32x the ce_1m rate.
REQ-004 SHALL have port reset_n  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have port ce_1m  in  1  one-clk strobe that marks each SID sample instant.
REQ-006 SHALL have port audio_l  in  18  signed left SID audio, sampled only on ce_1m.
REQ-007 SHALL have port audio_r  in  18  signed right SID audio, sampled only on ce_1m.
REQ-008 SHALL have port out_l  out  16  signed decimated left sample.
REQ-009 SHALL have port out_r  out  16  signed decimated right sample.
REQ-010 SHALL have port out_valid  out  1  out_l and out_r hold a sample that has not yet been taken.
REQ-011 SHALL have port out_ready  in  1  sink accepts the sample when out_valid and out_ready are both 1 on a clk edge.
REQ-012 SHALL have port overrun  out  1  sticky flag: at least one finished sample was dropped.

Function
REQ-013 Phase and window logic, on each ce_1m:
- phase (20 bit) += OUT_RATE;
- the window closes when phase + OUT_RATE >= IN_RATE; phase then takes that sum - IN_RATE.
REQ-014 Accumulation: on each ce_1m, acc_l/acc_r (24-bit signed) add the sign-extended audio; cnt (6-bit) increments.
REQ-015 Window close: SHALL hand sum = acc + current sample and n = cnt + 1 to the divider, and in the same clk clear acc to 0 and cnt to 0.
REQ-016 Sample counts: the OUT_RATE range guarantees n <= 63; n = 0 never reaches the divider.
REQ-017 Divider states:
- IDLE -> RUN on a window close;
- RUN lasts exactly 24 clks, one quotient bit per clk, restoring, on the magnitude;
- RUN -> DONE -> IDLE.
REQ-018 Quotient: q = sum/n, truncated toward zero, sign restored; result is an 18-bit signed value.
REQ-019 Output scaling: out = q[17:2] (arithmetic floor by 4); no saturation is needed.
REQ-020 Left and right SHALL divide in parallel and finish in the same clk.
REQ-021 Latency: out_valid SHALL rise exactly 26 clks after the clk edge that samples the window-closing ce_1m.
REQ-022 Output register: in DONE, if out_valid = 0 or out_ready = 1 that clk, SHALL load out_l/out_r and set out_valid = 1.
REQ-023 Overrun: in DONE, if out_valid = 1 and out_ready = 0, SHALL keep the held sample, drop the new one and set overrun = 1.
REQ-024 Accept: on out_valid & out_ready with no DONE in the same clk, out_valid SHALL fall next clk.
REQ-025 A ce_1m during RUN SHALL accumulate normally; a window close during RUN cannot occur (REQ-003) and needs no handling.
REQ-026 out_l/out_r SHALL stay stable while out_valid = 1 and out_ready = 0.

Reset
REQ-027 While reset_n = 0:
- phase, acc_l, acc_r and cnt = 0;
- divider in IDLE;
- out_l, out_r = 0;
- out_valid = 0, overrun = 0.
REQ-028 Reset asserted mid-RUN SHALL abort the division; no sample is emitted for that window.
REQ-029 Restart: the first window after reset_n rises starts at phase 0 with an empty accumulator.

Structure
REQ-030 Shared package sid_pkg SHALL hold:
- SID_AUDIO_W = 18, DEC_ACC_W = 24, DEC_CNT_W = 6;
- the divider state enum (IDLE/RUN/DONE).
REQ-031 Divider sub-module sid_div:
- signed 24-bit dividend by unsigned 6-bit divisor, 24-cycle sequential;
- start/done pulses;
- instantiated twice, once per channel.
REQ-032 The phase/accumulate logic and output handshake SHALL live in sid_decimator.

Verification
REQ-033 Constant audio_l = 131068, out_ready = 1 -> every out_l = 16'h7FFF.
REQ-034 Constant audio_r = -4 -> every out_r = 16'hFFFF; constant audio_l = 4 -> out_l = 1.
REQ-035 Default rates, 125 ce_1m from reset -> exactly 6 out_valid rises (windows of 20 or 21 samples); over 1,000,000 ce_1m -> 48000 rises.
REQ-036 Window n = 21 with samples 0..20 (sum 210) -> q = 10 -> out = 2; out_valid rises 26 clks after the closing ce_1m.
REQ-037 Backpressure: out_ready held 0 for 3 windows -> first sample held unchanged and overrun = 1; then out_ready = 1 -> out_valid falls, and the next window delivers fresh data.
REQ-038 Reset pulse 10 clks into RUN -> out_valid stays 0, overrun = 0, and the next window's average excludes all pre-reset samples.
